// File: rtl/redundant_flit_checker.sv
// Receives primary and redundant flit copies, aligns them in FIFOs, compares head pairs, forwards the primary copy and
// falls back to one channel on timeout. Write-to-valid_out latency 2 cycles; inputs stall only on a full FIFO; output holds under !ready_out.

module fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_wr_vld,
  input  logic [W-1:0] i_wr_dat,
  input  logic         i_rd_rdy,
  output logic         o_full,
  output logic         o_rd_vld,
  output logic [W-1:0] o_rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_empty;
  logic         w_wr;
  logic         w_rd;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign w_empty  = (r_wptr == r_rptr);
  assign o_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd     = i_rd_rdy && !w_empty;
  assign w_wr     = i_wr_vld && (!o_full || w_rd);
  assign o_rd_vld = !w_empty;
  assign o_rd_dat = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !i_rst && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_wr_dat;
  end
endmodule

module redundant_flit_checker #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYC     = 64
) (
  input  logic                  clk,
  input  logic                  reset_globle,
  input  logic [FLIT_WIDTH-1:0] flit_p,
  input  logic                  valid_p,
  output logic                  ready_p,
  input  logic [FLIT_WIDTH-1:0] flit_r,
  input  logic                  valid_r,
  output logic                  ready_r,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  err_mismatch,
  output logic [15:0]           mismatch_cnt,
  output logic                  lost_p,
  output logic                  lost_r
);
  localparam int             CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_DUAL, ST_SINGLE_P, ST_SINGLE_R} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_tmo_cnt;
  logic [CW-1:0]         w_tmo_nxt;
  logic [FLIT_WIDTH-1:0] r_flit_out;
  logic                  r_valid_out;
  logic                  r_err;
  logic [15:0]           r_mis_cnt;
  logic                  r_lost_p;
  logic                  r_lost_r;

  logic                  w_full_p, w_full_r;
  logic                  w_hd_p_vld, w_hd_r_vld;
  logic [FLIT_WIDTH-1:0] w_hd_p_dat, w_hd_r_dat;
  logic                  w_wr_p, w_wr_r;
  logic                  w_pop_p, w_pop_r;
  logic                  w_load;
  logic [FLIT_WIDTH-1:0] w_load_dat;
  logic                  w_mis;
  logic                  w_set_lost_p, w_set_lost_r;
  logic                  w_load_ok;

  // A lost channel keeps ready high so a babbling sender never stalls; its flits are dropped.
  assign ready_p   = !reset_globle && (r_lost_p || !w_full_p);
  assign ready_r   = !reset_globle && (r_lost_r || !w_full_r);
  assign w_wr_p    = valid_p && ready_p && !r_lost_p;
  assign w_wr_r    = valid_r && ready_r && !r_lost_r;
  assign w_load_ok = !r_valid_out || ready_out;

  fifo #(.W(FLIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_p (
    .clk(clk), .i_rst(reset_globle), .i_flush(w_set_lost_p),
    .i_wr_vld(w_wr_p), .i_wr_dat(flit_p), .i_rd_rdy(w_pop_p),
    .o_full(w_full_p), .o_rd_vld(w_hd_p_vld), .o_rd_dat(w_hd_p_dat)
  );

  fifo #(.W(FLIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_r (
    .clk(clk), .i_rst(reset_globle), .i_flush(w_set_lost_r),
    .i_wr_vld(w_wr_r), .i_wr_dat(flit_r), .i_rd_rdy(w_pop_r),
    .o_full(w_full_r), .o_rd_vld(w_hd_r_vld), .o_rd_dat(w_hd_r_dat)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_tmo_nxt    = '0;
    w_pop_p      = 1'b0;
    w_pop_r      = 1'b0;
    w_load       = 1'b0;
    w_load_dat   = w_hd_p_dat;
    w_mis        = 1'b0;
    w_set_lost_p = 1'b0;
    w_set_lost_r = 1'b0;
    case (r_state)
      ST_DUAL: begin
        if (w_hd_p_vld && w_hd_r_vld) begin
          if (w_load_ok) begin
            w_pop_p = 1'b1;
            w_pop_r = 1'b1;
            w_load  = 1'b1;
            w_mis   = (w_hd_p_dat != w_hd_r_dat);
          end
        end else if (w_hd_p_vld || w_hd_r_vld) begin
          // The lead counter runs even while the output is stalled.
          if (r_tmo_cnt == TO_LAST) begin
            if (w_hd_p_vld) begin
              w_state_nxt  = ST_SINGLE_P;
              w_set_lost_r = 1'b1;
            end else begin
              w_state_nxt  = ST_SINGLE_R;
              w_set_lost_p = 1'b1;
            end
          end else begin
            w_tmo_nxt = r_tmo_cnt + 1'b1;
          end
        end
      end
      ST_SINGLE_P: begin
        if (w_hd_p_vld && w_load_ok) begin
          w_pop_p = 1'b1;
          w_load  = 1'b1;
        end
      end
      ST_SINGLE_R: begin
        if (w_hd_r_vld && w_load_ok) begin
          w_pop_r    = 1'b1;
          w_load     = 1'b1;
          w_load_dat = w_hd_r_dat;
        end
      end
      default: w_state_nxt = ST_DUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_globle) begin
      r_state     <= ST_DUAL;
      r_tmo_cnt   <= '0;
      r_flit_out  <= '0;
      r_valid_out <= 1'b0;
      r_err       <= 1'b0;
      r_mis_cnt   <= '0;
      r_lost_p    <= 1'b0;
      r_lost_r    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      if (w_load) begin
        r_flit_out  <= w_load_dat;
        r_valid_out <= 1'b1;
      end else if (ready_out) begin
        r_valid_out <= 1'b0;
      end
      r_err <= w_mis;
      if (w_mis && (r_mis_cnt != 16'hFFFF)) r_mis_cnt <= r_mis_cnt + 16'd1;
      r_lost_p <= r_lost_p | w_set_lost_p;
      r_lost_r <= r_lost_r | w_set_lost_r;
    end
  end

  assign flit_out     = r_flit_out;
  assign valid_out    = r_valid_out;
  assign err_mismatch = r_err;
  assign mismatch_cnt = r_mis_cnt;
  assign lost_p       = r_lost_p;
  assign lost_r       = r_lost_r;
endmodule

// File: tb/tb_redundant_flit_checker.sv
// Random-stimulus bench for redundant_flit_checker against a queue-based model of the expected checked stream.
module tb_redundant_flit_checker;
  localparam int W     = 34;
  localparam int DEPTH = 4;
  localparam int TO    = 64;

  logic         clk = 1'b0;
  logic         reset_globle = 1'b1;
  logic [W-1:0] flit_p = '0, flit_r = '0;
  logic         valid_p = 1'b0, valid_r = 1'b0;
  logic         ready_p, ready_r;
  logic [W-1:0] flit_out;
  logic         valid_out;
  logic         ready_out = 1'b1;
  logic         err_mismatch;
  logic [15:0]  mismatch_cnt;
  logic         lost_p, lost_r;

  redundant_flit_checker #(.FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2), .FLIT_WIDTH(W),
                           .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_globle(reset_globle),
    .flit_p(flit_p), .valid_p(valid_p), .ready_p(ready_p),
    .flit_r(flit_r), .valid_r(valid_r), .ready_r(ready_r),
    .flit_out(flit_out), .valid_out(valid_out), .ready_out(ready_out),
    .err_mismatch(err_mismatch), .mismatch_cnt(mismatch_cnt),
    .lost_p(lost_p), .lost_r(lost_r)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] pf[$], rf[$];
  logic [W-1:0] exp_q[$];
  bit           expm_q[$];
  int           exp_mis = 0, pulses = 0;
  int           acc_p = 0, acc_r = 0;
  int           wr_cyc_p = -1, first_vo_cyc = -1, lost_r_cyc = -1;
  bit           mon_en = 1'b0, hold_prev = 1'b0;
  logic [W-1:0] prev_flit = '0;
  bit           rdy_rand = 1'b0, rdy_fixed = 1'b1;
  int           stall_pct = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  initial forever begin
    @(posedge clk); #1;
    ready_out = rdy_rand ? ($urandom_range(99) >= stall_pct) : rdy_fixed;
  end

  always @(negedge clk) begin
    bit front;
    if (valid_p && ready_p) begin
      acc_p++;
      if (wr_cyc_p < 0) wr_cyc_p = cyc;
    end
    if (valid_r && ready_r) acc_r++;
    if (valid_out && first_vo_cyc < 0) first_vo_cyc = cyc;
    if (lost_r && lost_r_cyc < 0) lost_r_cyc = cyc;
    if (mon_en) begin
      if (hold_prev) begin
        chk("hold_vld", 64'(valid_out), 64'(1));
        chk("hold_dat", 64'(flit_out), 64'(prev_flit));
      end
      if (err_mismatch) begin
        pulses++;
        front = (expm_q.size() > 0) ? expm_q[0] : 1'b0;
        chk("err_at_flit", 64'({valid_out, front}), 64'(2'b11));
      end
      if (valid_out && ready_out) begin
        chk("out_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          chk("flit", 64'(flit_out), 64'(exp_q.pop_front()));
          void'(expm_q.pop_front());
        end
      end
      hold_prev = valid_out && !ready_out;
      prev_flit = flit_out;
    end
  end

  task automatic clr_obs();
    acc_p = 0; acc_r = 0;
    wr_cyc_p = -1; first_vo_cyc = -1; lost_r_cyc = -1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset_globle = 1'b1; valid_p = 1'b0; valid_r = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_globle = 1'b0;
    exp_q.delete(); expm_q.delete();
    exp_mis = 0; pulses = 0; hold_prev = 1'b0;
    mon_en = 1'b1;
  endtask

  // Model: both copies carry the same sequence; output is the primary sequence, a differing pair is one mismatch.
  task automatic prep(input int n, input int mis_pct, input int mis_idx, input bit p_only);
    pf.delete(); rf.delete();
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] f, g;
      int           b;
      f = {2'($urandom_range(3)), $urandom()};
      g = f;
      if (p_only) g = {2'($urandom_range(3)), $urandom()};
      else if (i == mis_idx) g[0] = ~g[0];
      else if ($urandom_range(99) < mis_pct) begin
        b = $urandom_range(W-1);
        g[b] = ~g[b];
      end
      pf.push_back(f); rf.push_back(g);
      exp_q.push_back(f);
      expm_q.push_back(!p_only && (f != g));
      if (!p_only && f != g) exp_mis++;
    end
  endtask

  task automatic drive_ch(input bit ch, input int max_gap);
    int n;
    n = ch ? rf.size() : pf.size();
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      bit hs;
      int guard;
      if (ch) begin valid_r = 1'b1; flit_r = rf[i]; end
      else    begin valid_p = 1'b1; flit_p = pf[i]; end
      hs = 1'b0; guard = 0;
      while (!hs && guard < 2000) begin
        @(negedge clk); hs = ch ? ready_r : ready_p;
        @(posedge clk); #1; guard++;
      end
      chk(ch ? "handshake_r" : "handshake_p", 64'(hs), 64'(1));
      if (ch) valid_r = 1'b0; else valid_p = 1'b0;
      repeat ($urandom_range(max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin @(posedge clk); guard++; end
    chk("drain_left", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  task automatic run_stream(input int n, input int gap, input int stall, input int mis_pct,
                            input int mis_idx, input bit p_only);
    prep(n, mis_pct, mis_idx, p_only);
    stall_pct = stall; rdy_rand = (stall > 0);
    fork
      drive_ch(1'b0, gap);
      drive_ch(1'b1, gap);
    join
    rdy_rand = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bit           quiet;
    int           wc, guard;
    logic [W-1:0] x;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'({ready_p, ready_r}), 64'(0));
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    @(posedge clk); #1 reset_globle = 1'b0;
    @(negedge clk);
    chk("rst_outs", 64'({valid_out, err_mismatch, lost_p, lost_r}), 64'(0));
    chk("rst_cnt", 64'(mismatch_cnt), 64'(0));
    chk("rst_flit", 64'(flit_out), 64'(0));
    chk("rst_ready_after", 64'({ready_p, ready_r}), 64'(2'b11));
    mon_en = 1'b1;

    // Identical packets, latency of first flit.
    clr_obs();
    run_stream(16, 0, 0, 0, -1, 1'b0);
    chk("t1_latency", 64'(first_vo_cyc - wr_cyc_p), 64'(2));
    chk("t1_err_pulses", 64'(pulses), 64'(exp_mis));
    chk("t1_cnt", 64'(mismatch_cnt), 64'(exp_mis));

    // Bit-0 difference on flit 5 of R.
    run_stream(16, 0, 0, 0, 5, 1'b0);
    chk("t2_err_pulses", 64'(pulses), 64'(exp_mis));
    chk("t2_cnt", 64'(mismatch_cnt), 64'(exp_mis));

    // Random gaps, random stalls, random corruption.
    run_stream(40, 2, 30, 15, -1, 1'b0);
    chk("rnd_err_pulses", 64'(pulses), 64'(exp_mis));
    chk("rnd_cnt", 64'(mismatch_cnt), 64'(exp_mis));

    // R silent: lost_r exactly TO cycles after the P head becomes valid.
    clr_obs();
    prep(1, 0, -1, 1'b1);
    rf.delete();
    drive_ch(1'b0, 0);
    guard = 0;
    while (lost_r_cyc < 0 && guard < 300) begin @(posedge clk); guard++; end
    chk("t3_lost_time", 64'(lost_r_cyc - wr_cyc_p - 1), 64'(TO));
    drain();
    chk("t3_lost", 64'({lost_p, lost_r}), 64'(2'b01));
    chk("t3_ready_r", 64'(ready_r), 64'(1));
    run_stream(6, 1, 20, 0, -1, 1'b1);
    chk("t3_err_pulses", 64'(pulses), 64'(exp_mis));
    chk("t3_lost_sticky", 64'({lost_p, lost_r}), 64'(2'b01));

    // Reset pulsed mid-packet while in single-channel mode.
    mon_en = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      valid_p = 1'b1; flit_p = {2'($urandom_range(3)), $urandom()};
      @(posedge clk); #1;
    end
    reset_globle = 1'b1;
    @(negedge clk);
    chk("t6_rdy_in_rst", 64'({ready_p, ready_r}), 64'(0));
    @(posedge clk); #1;
    reset_globle = 1'b0; valid_p = 1'b0;
    @(negedge clk);
    chk("t6_outs", 64'({valid_out, err_mismatch, lost_p, lost_r}), 64'(0));
    chk("t6_cnt", 64'(mismatch_cnt), 64'(0));
    chk("t6_ready", 64'({ready_p, ready_r}), 64'(2'b11));
    quiet = 1'b1;
    repeat (4) begin @(negedge clk); if (valid_out) quiet = 1'b0; end
    chk("t6_dropped", 64'(quiet), 64'(1));
    exp_q.delete(); expm_q.delete(); exp_mis = 0; pulses = 0; hold_prev = 1'b0;
    mon_en = 1'b1;
    run_stream(16, 1, 20, 10, -1, 1'b0);
    chk("t6_err_pulses", 64'(pulses), 64'(exp_mis));
    chk("t6_cnt_after", 64'(mismatch_cnt), 64'(exp_mis));
    chk("t6_lost_clear", 64'({lost_p, lost_r}), 64'(0));

    // Output stalled 20 cycles while both channels stream.
    clr_obs();
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    prep(10, 0, -1, 1'b0);
    fork
      drive_ch(1'b0, 0);
      drive_ch(1'b1, 0);
      begin
        repeat (20) @(posedge clk);
        #2;
        chk("t4_acc_p", 64'(acc_p), 64'(DEPTH + 1));
        chk("t4_acc_r", 64'(acc_r), 64'(DEPTH + 1));
        chk("t4_ready_low", 64'({ready_p, ready_r}), 64'(0));
        rdy_fixed = 1'b1;
      end
    join
    drain();
    chk("t4_err_pulses", 64'(pulses), 64'(exp_mis));

    // R flit arriving in the expiry cycle is discarded.
    do_reset();
    @(posedge clk); #1;
    x = {2'($urandom_range(3)), $urandom()};
    valid_p = 1'b1; flit_p = x; wc = cyc;
    exp_q.push_back(x); expm_q.push_back(1'b0);
    @(negedge clk);
    chk("t5_p_ready", 64'(ready_p), 64'(1));
    @(posedge clk); #1 valid_p = 1'b0;
    while (cyc < wc + TO) begin @(posedge clk); #1; end
    valid_r = 1'b1; flit_r = ~x;
    @(negedge clk);
    chk("t5_r_ready", 64'(ready_r), 64'(1));
    chk("t5_lost_before", 64'(lost_r), 64'(0));
    @(posedge clk); #1 valid_r = 1'b0;
    @(negedge clk);
    chk("t5_lost", 64'({lost_p, lost_r}), 64'(2'b01));
    drain();
    run_stream(4, 0, 0, 0, -1, 1'b1);
    chk("t5_err_pulses", 64'(pulses), 64'(0));
    chk("t5_cnt", 64'(mismatch_cnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
